// File: rtl/tmds_bitslip_align.sv
// TMDS channel word aligner: pulses ISERDES bitslip until a run of control
// tokens is seen, then holds lock and watches for loss of alignment.
module tmds_bitslip_align #(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_SETTLE    = 16,
  parameter int SLIP_POSITIONS = 10,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       gclk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] word_in,
  input  logic       word_valid,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_count,
  output logic       sweep_fail,
  output logic [2:0] state_dbg
);

  localparam int RUN_W  = $clog2(TOKEN_RUN) + 1;
  localparam int TMR_W  = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int SET_W  = $clog2(SLIP_SETTLE) + 1;
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    SLIP    = 3'd2,
    SETTLE  = 3'd3,
    ALIGNED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [3:0]          slip_count_q, slip_count_d;
  logic                sweep_fail_q, sweep_fail_d;
  logic                bitslip_q, bitslip_d;
  logic                aligned_q, aligned_d;

  logic is_tok, tok_v, ntok_v, slip_wrap;

  // Control-token detect, qualified by word_valid
  always_comb begin
    is_tok = (word_in == 10'h354) || (word_in == 10'h0AB) ||
             (word_in == 10'h154) || (word_in == 10'h2AB);
    tok_v  = word_valid & is_tok;
    ntok_v = word_valid & ~is_tok;
    slip_wrap = (slip_count_q == 4'(SLIP_POSITIONS - 1));
  end

  // Next-state, counters and registered-output inputs
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    tmr_d        = tmr_q;
    set_d        = set_q;
    loss_d       = loss_q;
    slip_count_d = slip_count_q;
    sweep_fail_d = 1'b0;

    case (state_q)
      IDLE: begin
        run_d  = '0;
        tmr_d  = '0;
        set_d  = '0;
        loss_d = '0;
        if (enable) state_d = SEARCH;
      end
      SEARCH: begin
        if (tok_v) begin
          if (run_q != RUN_W'(TOKEN_RUN)) run_d = run_q + 1'b1;
        end else if (ntok_v) begin
          run_d = '0;
        end
        if (word_valid && tmr_q != TMR_W'(SEARCH_TIMEOUT)) tmr_d = tmr_q + 1'b1;
        // Lock takes priority over a timeout landing on the same word
        if (tok_v && run_q >= RUN_W'(TOKEN_RUN - 1)) begin
          state_d = ALIGNED;
          loss_d  = '0;
        end else if (word_valid && tmr_q == TMR_W'(SEARCH_TIMEOUT - 1)) begin
          state_d      = SLIP;
          slip_count_d = slip_wrap ? 4'd0 : slip_count_q + 4'd1;
          sweep_fail_d = slip_wrap;
        end
      end
      SLIP: begin
        state_d = SETTLE;
        set_d   = '0;
      end
      SETTLE: begin
        // Words in flight from the old slip position are discarded here
        run_d = '0;
        tmr_d = '0;
        if (set_q >= SET_W'(SLIP_SETTLE - 1)) begin
          state_d = SEARCH;
          set_d   = '0;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      ALIGNED: begin
        if (tok_v) begin
          loss_d = '0;
        end else if (ntok_v) begin
          if (loss_q >= LOSS_W'(LOSS_TIMEOUT - 1)) begin
            // Re-search from the current position; no slip on loss
            state_d = SEARCH;
            run_d   = '0;
            tmr_d   = '0;
            loss_d  = '0;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d      = IDLE;
      run_d        = '0;
      tmr_d        = '0;
      set_d        = '0;
      loss_d       = '0;
      slip_count_d = slip_count_q;
      sweep_fail_d = 1'b0;
    end

    bitslip_d = (state_d == SLIP);
    aligned_d = (state_d == ALIGNED);
  end

  // State and output registers
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      run_q        <= '0;
      tmr_q        <= '0;
      set_q        <= '0;
      loss_q       <= '0;
      slip_count_q <= '0;
      sweep_fail_q <= 1'b0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      tmr_q        <= tmr_d;
      set_q        <= set_d;
      loss_q       <= loss_d;
      slip_count_q <= slip_count_d;
      sweep_fail_q <= sweep_fail_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign slip_count = slip_count_q;
  assign sweep_fail = sweep_fail_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_tmds_bitslip_align.sv
// Bench for tmds_bitslip_align: directed stimulus pushes expected slip/lock
// events into a queue; a monitor pops and checks them as the DUT emits them.
module tb_tmds_bitslip_align;

  localparam int TR = 4, ST = 32, SS = 4, SP = 10, LT = 64;
  localparam int K_SLIP = 0, K_LOCK = 1, K_UNLOCK = 2;

  logic       gclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] word_in = '0;
  logic       word_valid = 1'b0;
  logic       bitslip, aligned, sweep_fail;
  logic [3:0] slip_count;
  logic [2:0] state_dbg;

  tmds_bitslip_align #(
    .TOKEN_RUN(TR), .SEARCH_TIMEOUT(ST), .SLIP_SETTLE(SS),
    .SLIP_POSITIONS(SP), .LOSS_TIMEOUT(LT)
  ) dut (
    .gclk(gclk), .reset(reset), .enable(enable), .word_in(word_in),
    .word_valid(word_valid), .bitslip(bitslip), .aligned(aligned),
    .slip_count(slip_count), .sweep_fail(sweep_fail), .state_dbg(state_dbg)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    int kind;
    int slip;
    int sweep;
    int state;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  nvec = 0, nerr = 0;
  int  cyc = 0, slip_seen = 0, last_slip_cyc = 0;
  logic prev_bitslip = 1'b0, prev_aligned = 1'b0;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int slip, input int sweep,
                      input int state, input int gap);
    ev_t e;
    e.kind = kind; e.slip = slip; e.sweep = sweep; e.state = state; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: sample away from the active edge, pop on every DUT event
  always @(negedge gclk) begin
    ev_t e;
    if (reset) begin
      prev_bitslip = 1'b0;
      prev_aligned = aligned;
    end else begin
      if (prev_bitslip) chk("bitslip_width", int'(bitslip), 0);
      if (sweep_fail && !bitslip) chk("sweep_fail_without_slip", 1, 0);
      if (bitslip && !prev_bitslip) begin
        slip_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_bitslip", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("slip_event_kind", K_SLIP, e.kind);
          chk("slip_count_at_slip", int'(slip_count), e.slip);
          chk("sweep_fail_at_slip", int'(sweep_fail), e.sweep);
          if (e.gap != 0) chk("slip_spacing", cyc - last_slip_cyc, e.gap);
        end
        last_slip_cyc = cyc;
      end
      if (aligned != prev_aligned) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_aligned_change", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("align_event_kind", aligned ? K_LOCK : K_UNLOCK, e.kind);
          chk("slip_count_at_align", int'(slip_count), e.slip);
          chk("state_at_align", int'(state_dbg), e.state);
        end
      end
      prev_bitslip = bitslip;
      prev_aligned = aligned;
    end
  end

  task automatic send(input logic v, input logic [9:0] w);
    word_valid = v;
    word_in    = w;
    @(posedge gclk);
    #1;
  endtask

  function automatic logic [9:0] rnd_nt();
    logic [9:0] w;
    w = 10'(($urandom_range(0, 1023)));
    while (w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB)
      w = w + 10'd1;
    return w;
  endfunction

  task automatic slip_wait(input int n);
    int base, budget;
    base = slip_seen;
    budget = 0;
    while (slip_seen < base + n && budget < 400) begin
      send(1'b1, rnd_nt());
      budget++;
    end
    if (slip_seen < base + n) chk("slip_wait_timeout", slip_seen - base, n);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_bitslip", int'(bitslip), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_slip_count", int'(slip_count), 0);
    chk("rst_sweep_fail", int'(sweep_fail), 0);
    chk("rst_state", int'(state_dbg), 0);
    reset = 1'b0;
    send(1'b0, '0);

    // 1: continuous tokens lock after the 4th valid word in SEARCH
    enable = 1'b1;
    push(K_LOCK, 0, 0, 4, 0);
    send(1'b1, 10'h354);           // IDLE -> SEARCH
    send(1'b1, 10'h354);
    send(1'b1, 10'h354);
    send(1'b1, 10'h354);
    chk("t1_not_yet_aligned", int'(aligned), 0);
    send(1'b1, 10'h354);
    chk("t1_aligned", int'(aligned), 1);
    repeat (10) send(1'b1, 10'h354);
    chk("t1_no_bitslip", slip_seen, 0);
    chk("t1_slip_count", int'(slip_count), 0);

    // Drop enable while aligned
    push(K_UNLOCK, 0, 0, 0, 0);
    enable = 1'b0;
    send(1'b0, '0);
    chk("t1_off_state", int'(state_dbg), 0);
    chk("t1_off_aligned", int'(aligned), 0);

    // 2: non-token data sweeps all 10 positions, 37 cycles apart
    for (int k = 0; k < SP; k++)
      push(K_SLIP, (k + 1) % SP, (k == SP - 1) ? 1 : 0, 2, (k == 0) ? 0 : 1 + SS + ST);
    enable = 1'b1;
    repeat (380) send(1'b1, rnd_nt());
    chk("t2_slips", slip_seen, 10);
    chk("t2_slip_count", int'(slip_count), 0);
    enable = 1'b0;
    send(1'b0, '0);
    chk("t2_off_state", int'(state_dbg), 0);

    // 3: pattern locks only after 3 slips
    push(K_SLIP, 1, 0, 2, 0);
    push(K_SLIP, 2, 0, 2, 1 + SS + ST);
    push(K_SLIP, 3, 0, 2, 1 + SS + ST);
    push(K_LOCK, 3, 0, 4, 0);
    enable = 1'b1;
    slip_wait(3);
    repeat (12) send(1'b1, 10'h0AB);
    chk("t3_aligned", int'(aligned), 1);
    chk("t3_slip_count", int'(slip_count), 3);
    chk("t3_total_slips", slip_seen, 13);

    // 4: a token within 63 words keeps lock; 64 non-tokens drop it
    repeat (LT - 1) send(1'b1, rnd_nt());
    send(1'b1, 10'h154);
    chk("t4_token_keeps_lock", int'(aligned), 1);
    repeat (20) begin
      send(1'b1, rnd_nt());
      send(1'b0, 10'h000);
    end
    repeat (LT - 1 - 20) send(1'b1, rnd_nt());
    chk("t4_63_nontokens_locked", int'(aligned), 1);
    push(K_UNLOCK, 3, 0, 1, 0);
    send(1'b1, rnd_nt());
    chk("t4_loss_aligned", int'(aligned), 0);
    chk("t4_loss_state", int'(state_dbg), 1);
    chk("t4_loss_slip_count", int'(slip_count), 3);

    // 5: broken run does not lock; invalid gaps do not break a run
    repeat (3) send(1'b1, 10'h2AB);
    send(1'b1, rnd_nt());
    repeat (3) send(1'b1, 10'h2AB);
    chk("t5_broken_run", int'(aligned), 0);
    send(1'b1, rnd_nt());
    push(K_LOCK, 3, 0, 4, 0);
    send(1'b1, 10'h354);
    send(1'b0, rnd_nt());
    send(1'b1, 10'h354);
    send(1'b0, 10'h354);
    send(1'b0, rnd_nt());
    send(1'b1, 10'h354);
    chk("t5_gap_run_not_yet", int'(aligned), 0);
    send(1'b0, rnd_nt());
    send(1'b1, 10'h354);
    chk("t5_gap_run_locks", int'(aligned), 1);

    // 6a: enable drop while aligned holds slip_count
    push(K_UNLOCK, 3, 0, 0, 0);
    enable = 1'b0;
    send(1'b1, 10'h354);
    chk("t6_off_aligned", int'(aligned), 0);
    chk("t6_off_bitslip", int'(bitslip), 0);
    chk("t6_off_state", int'(state_dbg), 0);
    chk("t6_off_slip_count", int'(slip_count), 3);
    enable = 1'b1;
    send(1'b1, rnd_nt());
    chk("t6_reen_state", int'(state_dbg), 1);
    chk("t6_reen_slip_count", int'(slip_count), 3);

    // 6b: async reset during SETTLE
    push(K_SLIP, 4, 0, 2, 0);
    slip_wait(1);
    chk("t6_in_settle", int'(state_dbg), 3);
    reset = 1'b1;
    #2;
    chk("t6_rst_state", int'(state_dbg), 0);
    chk("t6_rst_slip_count", int'(slip_count), 0);
    chk("t6_rst_bitslip", int'(bitslip), 0);
    chk("t6_rst_sweep_fail", int'(sweep_fail), 0);
    chk("t6_rst_aligned", int'(aligned), 0);
    repeat (2) send(1'b1, rnd_nt());
    reset = 1'b0;
    push(K_SLIP, 1, 0, 2, 0);
    send(1'b1, rnd_nt());
    chk("t6_restart_state", int'(state_dbg), 1);
    chk("t6_restart_slip_count", int'(slip_count), 0);
    slip_wait(1);
    chk("t6_restart_slip", int'(slip_count), 1);

    enable = 1'b0;
    repeat (3) send(1'b0, '0);
    chk("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
